// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the memory handshake responder
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, ACK} state_t;
  localparam logic [1:0] DL_BYTE = 2'b00;
  localparam logic [1:0] DL_HALF = 2'b01;
  localparam logic [1:0] DL_WORD = 2'b10;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/mem_read_formatter.sv
// mem_read_formatter: extends a big-endian fetched field to 32 bits
module mem_read_formatter import mem_pkg::*; (
  input  logic [31:0] fetched,
  input  logic [1:0]  dl,
  input  logic        sig,
  output logic [31:0] data
);
  always_comb
    data = dl == DL_BYTE ? {{24{sig & fetched[31]}}, fetched[31:24]} :
           dl == DL_HALF ? {{16{sig & fetched[31]}}, fetched[31:16]} : fetched;
endmodule

// File: rtl/mem_handshake_responder.sv
// mem_handshake_responder: MOV/MOC byte-addressed memory with wait states and extended reads
// Optional MEM_ALIGN_CHECK_EN adds align_err and suppresses misaligned half/word accesses.
module mem_handshake_responder import mem_pkg::*; #(
  parameter int DEPTH = 512,
  parameter int ADDR_W = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              mov,
  input  logic              rw,
  input  logic              sig,
  input  logic [1:0]        dl,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              moc
`ifdef MEM_ALIGN_CHECK_EN
  , output logic            align_err
`endif
);
  logic [7:0] mem [DEPTH];
  state_t state;
  logic [3:0] cnt;
  logic rw_q, sig_q;
  logic [1:0] dl_q;
  logic [ADDR_W-1:0] addr_q, a1, a2, a3;
  logic [31:0] din_q, fmt;
  logic mis;
  assign a1 = addr_q + ADDR_W'(1);
  assign a2 = addr_q + ADDR_W'(2);
  assign a3 = addr_q + ADDR_W'(3);
`ifdef MEM_ALIGN_CHECK_EN
  assign mis = (dl_q == DL_HALF && addr_q[0]) || (dl_q[1] && addr_q[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  mem_read_formatter u_fmt (
    .fetched({mem[addr_q], mem[a1], mem[a2], mem[a3]}),
    .dl(dl_q),
    .sig(sig_q),
    .data(fmt)
  );
  // moc trails ACK entry by one edge so it rises k+WAIT_CYCLES+2 after acceptance
  always_ff @(posedge main_clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      moc <= 1'b0;
      data_out <= '0;
      rw_q <= 1'b0;
      sig_q <= 1'b0;
      dl_q <= '0;
      addr_q <= '0;
      din_q <= '0;
    end else begin
      moc <= state == ACK && mov;
      case (state)
        IDLE: if (mov) begin
          rw_q <= rw;
          sig_q <= sig;
          dl_q <= dl;
          addr_q <= address;
          din_q <= data_in;
          cnt <= '0;
          state <= WAIT_CYCLES == 0 ? ACCESS : WAIT;
        end
        WAIT: if (!mov) state <= IDLE;
              else if (cnt == 4'(WAIT_CYCLES - 1)) state <= ACCESS;
              else cnt <= cnt + 4'd1;
        ACCESS: begin
          if (rw_q == RW_READ && !mis) data_out <= fmt;
          state <= ACK;
        end
        ACK: if (!mov) state <= IDLE;
      endcase
    end
`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge main_clk or negedge reset)
    if (!reset) align_err <= 1'b0;
    else align_err <= (state == ACCESS && mis) || (state == ACK && mov && align_err);
`endif
  // array is deliberately left out of reset
  always_ff @(posedge main_clk)
    if (state == ACCESS && rw_q == RW_WRITE && !mis) begin
      mem[addr_q] <= dl_q == DL_BYTE ? din_q[7:0] : dl_q == DL_HALF ? din_q[15:8] : din_q[31:24];
      if (dl_q != DL_BYTE) mem[a1] <= dl_q == DL_HALF ? din_q[7:0] : din_q[23:16];
      if (dl_q[1]) begin
        mem[a2] <= din_q[15:8];
        mem[a3] <= din_q[7:0];
      end
    end
endmodule
